ram_lane_block: RTL

- Parametrised single-clock simple-dual-port RAM; next generation of the team's 4Kb RAM block.
- Generalised in depth, width, lane-masked writes and read latency.
- Adds:
  - read enable with a valid strobe;
  - write-first bypass on same-address collisions;
  - hardware clear engine that zeroes the array after reset or on request.
- Used as the shared buffer for SD data-block and cipher-state storage.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_clear_fsm.sv | 66 ++++++
 rtl/ram_lane_block.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for ram_lane_block and its clear engine.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned LANES(input int unsigned data_width,
                                          input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

    // Even parity over a zero-extended lane; lanes wider than 64 bits are not supported.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks every address once after reset or on clear_req, asserting
// busy and a zero-write strobe for exactly DEPTH cycles.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        unique case (state_q)
            ST_CLEAR: begin
                // clr_addr parks at the last address rather than wrapping
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/ram_lane_block.sv
// Simple-dual-port lane-masked RAM with write-first bypass, optional output register
// and hardware clear. Optional per-lane parity: define RAM_LANE_BLOCK_PARITY_EN.
module ram_lane_block
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear_req,
    output logic                                    busy,
    input  logic                                    write_en,
    input  logic [LANES(DATA_WIDTH, LANE_WIDTH)-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]                   waddr,
    input  logic [DATA_WIDTH-1:0]                   din,
    input  logic                                    read_en,
    input  logic [ADDR_WIDTH-1:0]                   raddr,
`ifdef RAM_LANE_BLOCK_PARITY_EN
    input  logic                                    par_flip,
    output logic                                    parity_err,
`endif
    output logic [DATA_WIDTH-1:0]                   dout,
    output logic                                    dout_valid
);

    localparam int unsigned NUM_LANES = LANES(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic                  rd_acc;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] byp_rdata;
    logic [NUM_LANES-1:0]  byp_lanes;

    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_acc = write_en & ~busy;
    assign rd_acc = read_en & ~busy;

`ifdef RAM_LANE_BLOCK_PARITY_EN
    logic [NUM_LANES-1:0] par_mem [DEPTH];
    logic [NUM_LANES-1:0] par_rdata;
    logic                 rd_err_q, rd_err_d;
`endif

    // clr_we and wr_acc are mutually exclusive because both key off busy
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            par_mem[clr_addr] <= '0;
`endif
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= din[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef RAM_LANE_BLOCK_PARITY_EN
                    par_mem[waddr][i] <= even_parity(64'(din[i*LANE_WIDTH +: LANE_WIDTH])) ^ par_flip;
`endif
                end
            end
        end
    end

    always_comb begin
        mem_rdata = mem[raddr];
        byp_lanes = (wr_acc && (waddr == raddr)) ? wmask : '0;
        byp_rdata = mem_rdata;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (byp_lanes[i]) begin
                byp_rdata[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? byp_rdata : rd_data_q;
    end

`ifdef RAM_LANE_BLOCK_PARITY_EN
    // Bypassed lanes carry live din, so only array-sourced lanes are checked
    always_comb begin
        par_rdata = par_mem[raddr];
        rd_err_d  = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!byp_lanes[i] &&
                (even_parity(64'(mem_rdata[i*LANE_WIDTH +: LANE_WIDTH])) != par_rdata[i])) begin
                rd_err_d = rd_acc;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            rd_err_q   <= 1'b0;
`endif
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            rd_err_q   <= rd_err_d;
`endif
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
            logic                  out_valid_q, out_valid_d;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            logic                  out_err_q, out_err_d;
`endif

            always_comb begin
                out_valid_d = rd_valid_q;
                out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
`ifdef RAM_LANE_BLOCK_PARITY_EN
                out_err_d   = rd_err_q;
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
`ifdef RAM_LANE_BLOCK_PARITY_EN
                    out_err_q   <= 1'b0;
`endif
                end else begin
                    out_data_q  <= out_data_d;
                    out_valid_q <= out_valid_d;
`ifdef RAM_LANE_BLOCK_PARITY_EN
                    out_err_q   <= out_err_d;
`endif
                end
            end

            assign dout       = out_data_q;
            assign dout_valid = out_valid_q;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            assign parity_err = out_err_q;
`endif
        end else begin : g_no_out_reg
            assign dout       = rd_data_q;
            assign dout_valid = rd_valid_q;
`ifdef RAM_LANE_BLOCK_PARITY_EN
            assign parity_err = rd_err_q;
`endif
        end
    endgenerate

endmodule
